// File: rtl/spectrum_pkg.sv
// spectrum_pkg: shared types and elaboration-time helpers for spectrum_band_analyzer.
//   state_e     - analyser FSM states
//   clog2       - ceiling log2, usable in parameter expressions
//   mid_scale   - ADC mid-scale code for a given sample width
//   acc_width   - per-band accumulator width (sample width + log2 samples-per-band)
package spectrum_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCapture,
        StScale,
        StOutput
    } state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result++;
        end
        return result;
    endfunction

    function automatic int unsigned mid_scale(input int unsigned data_w);
        return 32'd1 << (data_w - 1);
    endfunction

    function automatic int unsigned acc_width(input int unsigned data_w,
                                              input int unsigned n_samples,
                                              input int unsigned n_bands);
        return data_w + clog2(n_samples / n_bands);
    endfunction

endpackage

// File: rtl/spectrum_band_analyzer_band_scaler.sv
// band_scaler: combinational gain multiply, shift and saturation for one band.
//   acc   - band accumulator
//   gain  - gain (2^GAIN_SHIFT is unity)
//   value - scaled result, clipped to 2^OUT_W-1
//   clip  - high when the full-width product exceeded the output range
module band_scaler #(
    parameter int unsigned ACC_W      = 11,
    parameter int unsigned GAIN_W     = 8,
    parameter int unsigned GAIN_SHIFT = 7,
    parameter int unsigned OUT_W      = 12
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [GAIN_W-1:0] gain,
    output logic [OUT_W-1:0]  value,
    output logic              clip
);

    localparam int unsigned ProdW = ACC_W + GAIN_W;
    localparam logic [ProdW-1:0] MaxVal = ProdW'((64'd1 << OUT_W) - 64'd1);

    logic [ProdW-1:0] product;
    logic [ProdW-1:0] shifted;

    always_comb begin
        product = ProdW'(acc) * ProdW'(gain);
        shifted = product >> GAIN_SHIFT;
        clip    = shifted > MaxVal;
        value   = clip ? MaxVal[OUT_W-1:0] : shifted[OUT_W-1:0];
    end

endmodule

// File: rtl/spectrum_band_analyzer.sv
// spectrum_band_analyzer: captures a frame of N_SAMPLES ADC samples, accumulates the absolute
// deviation from mid-scale per band, applies gain with saturation (one band per cycle through
// a shared band_scaler) and presents the packed magnitudes over a valid/ready handshake.
// Optional feature macro: SPECTRUM_PEAK_HOLD_EN adds per-band peak hold with decay.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   adc_data, adc_valid   - sample and strobe (accepted in CAPTURE only)
//   trigger               - frame start, honoured in IDLE only
//   gain                  - gain, latched on the first SCALE cycle
//   spectrum_data_packed  - band b at [b*OUT_W +: OUT_W]
//   spectrum_valid/ready  - output handshake
//   saturated             - a band clipped in the presented frame
//   busy                  - not IDLE
module spectrum_band_analyzer
    import spectrum_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned N_SAMPLES   = 64,
    parameter int unsigned N_BANDS     = 8,
    parameter int unsigned OUT_W       = 12,
    parameter int unsigned GAIN_W      = 8,
    parameter int unsigned GAIN_SHIFT  = 7,
    parameter int unsigned DECAY_SHIFT = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        adc_data,
    input  logic                     adc_valid,
    input  logic                     trigger,
    input  logic [GAIN_W-1:0]        gain,
    output logic [N_BANDS*OUT_W-1:0] spectrum_data_packed,
    output logic                     spectrum_valid,
    input  logic                     spectrum_ready,
    output logic                     saturated,
    output logic                     busy
);

    localparam int unsigned Spb   = N_SAMPLES / N_BANDS;
    localparam int unsigned AccW  = acc_width(DATA_W, N_SAMPLES, N_BANDS);
    localparam int unsigned CntW  = (clog2(N_SAMPLES) > 0) ? clog2(N_SAMPLES) : 1;
    localparam int unsigned BandW = (clog2(N_BANDS) > 0) ? clog2(N_BANDS) : 1;
    localparam int unsigned SpbSh = clog2(Spb);
    localparam logic [DATA_W-1:0] Mid      = DATA_W'(mid_scale(DATA_W));
    localparam logic [CntW-1:0]   LastCnt  = CntW'(N_SAMPLES - 1);
    localparam logic [BandW-1:0]  LastBand = BandW'(N_BANDS - 1);

    state_e state_q, state_d;

    logic [CntW-1:0]   cnt_q;
    logic [BandW-1:0]  band_q;
    logic [AccW-1:0]   acc_q   [N_BANDS];
    logic [OUT_W-1:0]  stage_q [N_BANDS];
    logic              stage_sat_q;
    logic [GAIN_W-1:0] gain_q;
    logic [N_BANDS*OUT_W-1:0] data_q;
    logic              valid_q;
    logic              sat_q;

    logic              sample_fire;
    logic              handshake;
    logic              load;
    logic [DATA_W-1:0] dev;
    logic [BandW-1:0]  acc_sel;
    logic [GAIN_W-1:0] gain_eff;
    logic [OUT_W-1:0]  scaled_val;
    logic              scaled_clip;
    logic [OUT_W-1:0]  load_val [N_BANDS];

    assign sample_fire = (state_q == StCapture) && adc_valid;
    assign handshake   = valid_q && spectrum_ready;
    // Staging is complete only one edge after the last SCALE cycle, so the output load
    // happens in the first OUTPUT cycle rather than on the SCALE->OUTPUT edge.
    assign load        = (state_q == StOutput) && !valid_q;
    assign dev         = (adc_data >= Mid) ? (adc_data - Mid) : (Mid - adc_data);
    assign acc_sel     = BandW'(cnt_q >> SpbSh);
    // Band 0 uses the live gain; the same value is latched for the remaining bands.
    assign gain_eff    = (band_q == '0) ? gain : gain_q;

    band_scaler #(
        .ACC_W      (AccW),
        .GAIN_W     (GAIN_W),
        .GAIN_SHIFT (GAIN_SHIFT),
        .OUT_W      (OUT_W)
    ) u_band_scaler (
        .acc   (acc_q[band_q]),
        .gain  (gain_eff),
        .value (scaled_val),
        .clip  (scaled_clip)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (trigger) state_d = StCapture;
            StCapture: if (sample_fire && (cnt_q == LastCnt)) state_d = StScale;
            StScale:   if (band_q == LastBand) state_d = StOutput;
            StOutput:  if (handshake) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            band_q      <= '0;
            stage_sat_q <= 1'b0;
            gain_q      <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            sat_q       <= 1'b0;
            for (int b = 0; b < N_BANDS; b++) begin
                acc_q[b]   <= '0;
                stage_q[b] <= '0;
            end
        end else begin
            if ((state_q == StIdle) && trigger) begin
                cnt_q <= '0;
                for (int b = 0; b < N_BANDS; b++) begin
                    acc_q[b] <= '0;
                end
            end
            if (sample_fire) begin
                acc_q[acc_sel] <= acc_q[acc_sel] + AccW'(dev);
                cnt_q          <= cnt_q + 1'b1;
            end
            if (state_q == StScale) begin
                stage_q[band_q] <= scaled_val;
                stage_sat_q     <= (band_q == '0) ? scaled_clip : (stage_sat_q | scaled_clip);
                if (band_q == '0) begin
                    gain_q <= gain;
                end
                band_q <= (band_q == LastBand) ? '0 : band_q + 1'b1;
            end
            if (load) begin
                for (int b = 0; b < N_BANDS; b++) begin
                    data_q[b*OUT_W +: OUT_W] <= load_val[b];
                end
                sat_q   <= stage_sat_q;
                valid_q <= 1'b1;
            end else if (handshake) begin
                valid_q <= 1'b0;
            end
        end
    end

`ifdef SPECTRUM_PEAK_HOLD_EN
    logic [OUT_W-1:0] hold_q  [N_BANDS];
    logic [OUT_W-1:0] decayed [N_BANDS];

    always_comb begin
        for (int b = 0; b < N_BANDS; b++) begin
            decayed[b]  = hold_q[b] - (hold_q[b] >> DECAY_SHIFT);
            load_val[b] = (stage_q[b] > decayed[b]) ? stage_q[b] : decayed[b];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < N_BANDS; b++) begin
                hold_q[b] <= '0;
            end
        end else if (load) begin
            for (int b = 0; b < N_BANDS; b++) begin
                hold_q[b] <= load_val[b];
            end
        end
    end
`else
    logic unused_decay;
    assign unused_decay = ^DECAY_SHIFT;

    always_comb begin
        for (int b = 0; b < N_BANDS; b++) begin
            load_val[b] = stage_q[b];
        end
    end
`endif

    assign spectrum_data_packed = data_q;
    assign spectrum_valid       = valid_q;
    assign saturated            = sat_q;
    assign busy                 = (state_q != StIdle);

endmodule

// File: tb/tb_spectrum_band_analyzer.sv
// Bench for spectrum_band_analyzer: a 12-bit and a 10-bit output instance share stimulus.
// Expected band values come from a frame-level arithmetic model (sum of deviations, product,
// clip, optional peak hold) plus a table of hand-derived constants.
module tb_spectrum_band_analyzer;

    localparam int NS = 64;
    localparam int NB = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  adc_data = '0;
    logic        adc_valid = 1'b0;
    logic        trigger = 1'b0;
    logic [7:0]  gain = '0;
    logic        ready = 1'b0;

    logic [95:0] data12;
    logic        valid12, sat12, busy12;
    logic [79:0] data10;
    logic        valid10, sat10, busy10;

    always #5 clk = ~clk;

    spectrum_band_analyzer #(.DECAY_SHIFT(2)) dut (
        .clk(clk), .rst_n(rst_n), .adc_data(adc_data), .adc_valid(adc_valid),
        .trigger(trigger), .gain(gain), .spectrum_data_packed(data12),
        .spectrum_valid(valid12), .spectrum_ready(ready), .saturated(sat12), .busy(busy12)
    );

    spectrum_band_analyzer #(.OUT_W(10)) dut10 (
        .clk(clk), .rst_n(rst_n), .adc_data(adc_data), .adc_valid(adc_valid),
        .trigger(trigger), .gain(gain), .spectrum_data_packed(data10),
        .spectrum_valid(valid10), .spectrum_ready(ready), .saturated(sat10), .busy(busy10)
    );

    int checks = 0;
    int failures = 0;
    int smp [NS];
    int e12 [NB];
    int e10 [NB];
    int h12 [NB];
    int h10 [NB];
    bit s12, s10;

    typedef struct {
        int    pat;
        int    g;
        int    gap;
        int    stall;
        int    exp12;
        int    exps12;
        int    exp10;
        int    exps10;
        string name;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic fill(input int pat);
        for (int i = 0; i < NS; i++) begin
            case (pat)
                0:       smp[i] = 128;
                1:       smp[i] = (i % 2 == 0) ? 0 : 255;
                2:       smp[i] = 0;
                default: smp[i] = int'($urandom_range(0, 255));
            endcase
        end
    endtask

    task automatic clear_holds();
        for (int b = 0; b < NB; b++) begin
            h12[b] = 0;
            h10[b] = 0;
        end
    endtask

    task automatic model_frame(input int g);
        int sum, p, n12, n10;
        s12 = 0;
        s10 = 0;
        for (int b = 0; b < NB; b++) begin
            sum = 0;
            for (int i = b * (NS / NB); i < (b + 1) * (NS / NB); i++) begin
                sum += (smp[i] >= 128) ? smp[i] - 128 : 128 - smp[i];
            end
            p   = (sum * g) / 128;
            n12 = (p > 4095) ? 4095 : p;
            n10 = (p > 1023) ? 1023 : p;
            if (p > 4095) s12 = 1;
            if (p > 1023) s10 = 1;
`ifdef SPECTRUM_PEAK_HOLD_EN
            begin
                int d12, d10;
                d12 = h12[b] - h12[b] / 4;
                d10 = h10[b] - h10[b] / 8;
                e12[b] = (n12 > d12) ? n12 : d12;
                e10[b] = (n10 > d10) ? n10 : d10;
                h12[b] = e12[b];
                h10[b] = e10[b];
            end
`else
            e12[b] = n12;
            e10[b] = n10;
`endif
        end
    endtask

    // One full frame: trigger, samples with `gap` idle cycles before each, wait for valid,
    // optional stall with a trigger pulse, then handshake (trigger high on the handshake
    // edge when stalling, which must be ignored).
    task automatic do_frame(input int g, input int gap, input int stall, input string tag);
        int n;
        logic [95:0] snap12;
        logic [79:0] snap10;
        gain = 8'($urandom);
        trigger = 1'b1;
        @(posedge clk); #1;
        trigger = 1'b0;
        check({tag, " busy_after_trigger"}, busy12, 1);
        for (int i = 0; i < NS; i++) begin
            for (int j = 0; j < gap; j++) begin
                adc_valid = 1'b0;
                adc_data  = 8'($urandom);
                @(posedge clk); #1;
            end
            if (i == NS - 1) gain = 8'(g);
            adc_valid = 1'b1;
            adc_data  = 8'(smp[i]);
            @(posedge clk); #1;
        end
        adc_valid = 1'b0;
        @(posedge clk); #1;
        gain = 8'($urandom);
        n = 1;
        while (!valid12 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " valid_latency"}, n, NB + 1);
        check({tag, " valid10"}, valid10, 1);
        for (int b = 0; b < NB; b++) begin
            check({tag, $sformatf(" band12[%0d]", b)}, data12[b*12 +: 12], e12[b]);
            check({tag, $sformatf(" band10[%0d]", b)}, data10[b*10 +: 10], e10[b]);
        end
        check({tag, " sat12"}, sat12, s12);
        check({tag, " sat10"}, sat10, s10);
        snap12 = data12;
        snap10 = data10;
        if (stall > 0) begin
            for (int c = 0; c < stall; c++) begin
                trigger = (c == stall / 2);
                @(posedge clk); #1;
            end
            trigger = 1'b0;
            check({tag, " stall_valid"}, valid12, 1);
            check({tag, " stall_busy"}, busy12, 1);
            check({tag, " stall_data12"}, data12, snap12);
            check({tag, " stall_data10"}, data10, snap10);
        end
        ready = 1'b1;
        trigger = (stall > 0);
        @(posedge clk); #1;
        ready = 1'b0;
        trigger = 1'b0;
        check({tag, " post_hs_valid"}, valid12, 0);
        check({tag, " post_hs_busy"}, busy12, 0);
        check({tag, " post_hs_data"}, data12, snap12);
        check({tag, " post_hs_sat10"}, sat10, s10);
    endtask

    initial begin
        vecs[0] = '{0, 128, 0, 0,  0,    0, 0,    0, "mid"};
        vecs[1] = '{1, 128, 0, 20, 1020, 0, 1020, 0, "alt_g128"};
        vecs[2] = '{1, 255, 0, 0,  2032, 0, 1023, 1, "alt_g255"};
        vecs[3] = '{2, 255, 0, 0,  2040, 0, 1023, 1, "zero_g255"};
        vecs[4] = '{1, 128, 2, 0,  1020, 0, 1020, 0, "alt_gap3"};
        clear_holds();

        repeat (2) @(posedge clk);
        #1;
        check("reset data", data12, 0);
        check("reset valid", valid12, 0);
        check("reset sat", sat12, 0);
        check("reset busy", busy12, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

`ifdef SPECTRUM_PEAK_HOLD_EN
        fill(1); model_frame(128); do_frame(128, 0, 0, "hold1");
        check("hold1 const", data12[11:0], 1020);
        fill(0); model_frame(128); do_frame(128, 0, 0, "hold2");
        check("hold2 const", data12[11:0], 765);
        fill(0); model_frame(128); do_frame(128, 0, 0, "hold3");
        check("hold3 const", data12[11:0], 574);
`endif

        foreach (vecs[v]) begin
            fill(vecs[v].pat);
            model_frame(vecs[v].g);
            do_frame(vecs[v].g, vecs[v].gap, vecs[v].stall, vecs[v].name);
`ifndef SPECTRUM_PEAK_HOLD_EN
            check({vecs[v].name, " const12_b0"}, data12[11:0], vecs[v].exp12);
            check({vecs[v].name, " const12_b7"}, data12[95:84], vecs[v].exp12);
            check({vecs[v].name, " const10_b0"}, data10[9:0], vecs[v].exp10);
            check({vecs[v].name, " const_sat12"}, sat12, vecs[v].exps12);
            check({vecs[v].name, " const_sat10"}, sat10, vecs[v].exps10);
`endif
        end

        for (int r = 0; r < 6; r++) begin
            int g, gap;
            g   = int'($urandom_range(0, 255));
            gap = int'($urandom_range(0, 2));
            fill(3);
            model_frame(g);
            do_frame(g, gap, 0, $sformatf("rand%0d", r));
        end

        // Reset mid-capture after 30 samples.
        fill(3);
        gain = 8'd200;
        trigger = 1'b1;
        @(posedge clk); #1;
        trigger = 1'b0;
        for (int i = 0; i < 30; i++) begin
            adc_valid = 1'b1;
            adc_data  = 8'(smp[i]);
            @(posedge clk); #1;
        end
        adc_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset data12", data12, 0);
        check("midreset data10", data10, 0);
        check("midreset valid", valid12, 0);
        check("midreset sat10", sat10, 0);
        check("midreset busy", busy12, 0);
        clear_holds();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        fill(3);
        model_frame(255);
        do_frame(255, 1, 0, "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
